// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the read-return FSM encoding, the read-owner encoding and parameter defaults.
package mem_arbiter_pkg;

    localparam int MAX_D_BURST_DEF = 2;
    localparam int RAM_AW_DEF      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RET_I = 2'd1,
        RET_D = 2'd2
    } ret_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering between the 32-bit data port and the RAM:
// store byte-enable/data replication and load lane extraction with zero extension.
module mem_byte_lane (
    input  logic        st_byte_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    input  logic        ld_byte_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);

    logic [7:0] ld_sel;

    always_comb begin
        st_be_o   = st_byte_i ? (4'b0001 << st_lane_i) : 4'b1111;
        st_data_o = st_byte_i ? {4{st_data_i[7:0]}} : st_data_i;

        case (ld_lane_i)
            2'd0:    ld_sel = ld_data_i[7:0];
            2'd1:    ld_sel = ld_data_i[15:8];
            2'd2:    ld_sel = ld_data_i[23:16];
            default: ld_sel = ld_data_i[31:24];
        endcase
        ld_data_o = ld_byte_i ? {24'd0, ld_sel} : ld_data_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port RAM with a
// bounded data burst while fetch waits, and returns read data one cycle after grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = MAX_D_BURST_DEF,
    parameter int RAM_AW      = RAM_AW_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byteop,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    ret_state_e       state_q, state_d;
    owner_e           rd_owner_q;
    logic             rd_byte_q;
    logic [1:0]       rd_lane_q;
    logic [31:0]      i_rdata_q, d_rdata_q;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_rdata;
    logic             d_wins;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:RAM_AW+2], i_addr[1:0], d_addr[31:RAM_AW+2]};

    mem_byte_lane u_lane (
        .st_byte_i (d_byteop),
        .st_lane_i (d_addr[1:0]),
        .st_data_i (d_wdata),
        .st_be_o   (lane_be),
        .st_data_o (lane_wdata),
        .ld_byte_i (rd_byte_q),
        .ld_lane_i (rd_lane_q),
        .ld_data_i (ram_rdata),
        .ld_data_o (lane_rdata)
    );

    // Data has priority until it has taken MAX_D_BURST grants in a row over a waiting fetch.
    always_comb begin
        d_wins    = i_req ? (burst_cnt_q < CNT_MAX) : 1'b1;
        d_gnt     = !Reset && d_req && d_wins;
        i_gnt     = !Reset && i_req && !d_gnt;
        ram_en    = i_gnt || d_gnt;
        ram_we    = d_gnt && d_we;
        ram_be    = ram_we ? lane_be : 4'b0000;
        ram_wdata = lane_wdata;
        ram_addr  = d_gnt ? d_addr[RAM_AW+1:2] : i_addr[RAM_AW+1:2];
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!i_req || i_gnt) begin
            burst_cnt_d = '0;
        end else if (d_gnt && (burst_cnt_q < CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end

        if (i_gnt) begin
            state_d = RET_I;
        end else if (d_gnt && !d_we) begin
            state_d = RET_D;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            burst_cnt_q <= '0;
            state_q     <= IDLE;
            rd_owner_q  <= OWNER_I;
            rd_byte_q   <= 1'b0;
            rd_lane_q   <= 2'd0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            state_q     <= state_d;
            if (i_gnt) begin
                rd_owner_q <= OWNER_I;
            end else if (d_gnt && !d_we) begin
                rd_owner_q <= OWNER_D;
                rd_byte_q  <= d_byteop;
                rd_lane_q  <= d_addr[1:0];
            end
            // Capture the returned word so each port's rdata holds between returns.
            if (state_q != IDLE && rd_owner_q == OWNER_I) begin
                i_rdata_q <= ram_rdata;
            end
            if (state_q != IDLE && rd_owner_q == OWNER_D) begin
                d_rdata_q <= lane_rdata;
            end
        end
    end

    // A reset in the return cycle drops that return.
    assign i_rvalid = (state_q == RET_I) && !Reset;
    assign d_rvalid = (state_q == RET_D) && !Reset;
    assign i_rdata  = i_rvalid ? ram_rdata : i_rdata_q;
    assign d_rdata  = d_rvalid ? lane_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_byteop;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:1023];

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_D_BURST(2), .RAM_AW(10)) dut (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_byteop(d_byteop), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM model: byte-lane writes, registered read.
    always @(posedge CLK) begin
        if (Reset) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'd0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int l = 0; l < 4; l++)
                    if (ram_be[l]) mem[ram_addr][8*l +: 8] <= ram_wdata[8*l +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        string       name;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req, d_we, d_byteop;
        logic [31:0] d_addr, d_wdata;
        logic        e_i_gnt, e_d_gnt, e_we;
        logic [3:0]  e_be;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic        chk_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        byteop;
        logic [31:0] exp;
    } ld_t;

    vec_t vecs[10];
    ld_t  lds[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_byteop = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic d_load(input logic [31:0] a, input logic b);
        d_req = 1'b1; d_we = 1'b0; d_byteop = b; d_addr = a;
    endtask

    logic [5:0] exp_d;
    logic [5:0] pat;

    initial begin
        vecs[0] = '{"word_store_w4",   1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 4'hF, 10'd4,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{"fetch_only",      1'b1, 32'h10,  1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 4'h0, 10'd4,  32'h0,        1'b0};
        vecs[2] = '{"no_request",      1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 10'd0,  32'h0,        1'b0};
        vecs[3] = '{"word_store",      1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h20,       32'h12345678, 1'b0, 1'b1, 1'b1, 4'hF, 10'd8,  32'h12345678, 1'b1};
        vecs[4] = '{"byte_store_l0",   1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h40,       32'h123456CD, 1'b0, 1'b1, 1'b1, 4'h1, 10'd16, 32'hCDCDCDCD, 1'b1};
        vecs[5] = '{"byte_store_l1",   1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h41,       32'h00000011, 1'b0, 1'b1, 1'b1, 4'h2, 10'd16, 32'h11111111, 1'b1};
        vecs[6] = '{"byte_store_l2",   1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h42,       32'h00000022, 1'b0, 1'b1, 1'b1, 4'h4, 10'd16, 32'h22222222, 1'b1};
        vecs[7] = '{"load_vs_fetch",   1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h20,       32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 10'd8,  32'h0,        1'b0};
        vecs[8] = '{"bstore_vs_fetch", 1'b1, 32'h10,  1'b1, 1'b1, 1'b1, 32'h47,       32'h0000005A, 1'b0, 1'b1, 1'b1, 4'h8, 10'd17, 32'h5A5A5A5A, 1'b1};
        vecs[9] = '{"high_addr_bits",  1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'hFFFFF00C, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 4'hF, 10'd3,  32'hCAFEF00D, 1'b1};

        lds[0] = '{32'h40, 1'b0, 32'h002211CD};
        lds[1] = '{32'h41, 1'b1, 32'h00000011};
        lds[2] = '{32'h42, 1'b1, 32'h00000022};
        lds[3] = '{32'h47, 1'b1, 32'h0000005A};
        lds[4] = '{32'h20, 1'b0, 32'h12345678};
        lds[5] = '{32'h0C, 1'b0, 32'hCAFEF00D};
        lds[6] = '{32'h40, 1'b1, 32'h000000CD};

        // Reset with requests pending: nothing may be granted.
        Reset = 1'b1;
        idle();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10;
        repeat (2) next_cycle();
        @(negedge CLK);
        check("rst_i_gnt",  {31'd0, i_gnt},  32'd0);
        check("rst_d_gnt",  {31'd0, d_gnt},  32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_be", {28'd0, ram_be}, 32'd0);
        next_cycle();
        Reset = 1'b0;
        idle();
        check("post_rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        check("post_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("post_rst_i_rdata",  i_rdata, 32'd0);
        check("post_rst_d_rdata",  d_rdata, 32'd0);
        next_cycle();

        // Single-cycle vectors, each applied with burst count cleared by an idle cycle.
        for (int v = 0; v < 10; v++) begin
            i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
            d_req = vecs[v].d_req; d_we = vecs[v].d_we; d_byteop = vecs[v].d_byteop;
            d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
            @(negedge CLK);
            $display("vec %0d %s: i_gnt=%b d_gnt=%b we=%b be=%h addr=%0d wdata=%h",
                     v, vecs[v].name, i_gnt, d_gnt, ram_we, ram_be, ram_addr, ram_wdata);
            check({vecs[v].name, "_i_gnt"},  {31'd0, i_gnt},  {31'd0, vecs[v].e_i_gnt});
            check({vecs[v].name, "_d_gnt"},  {31'd0, d_gnt},  {31'd0, vecs[v].e_d_gnt});
            check({vecs[v].name, "_ram_en"}, {31'd0, ram_en}, {31'd0, vecs[v].e_i_gnt | vecs[v].e_d_gnt});
            check({vecs[v].name, "_ram_we"}, {31'd0, ram_we}, {31'd0, vecs[v].e_we});
            check({vecs[v].name, "_ram_be"}, {28'd0, ram_be}, {28'd0, vecs[v].e_be});
            check({vecs[v].name, "_addr"},   {22'd0, ram_addr}, {22'd0, vecs[v].e_addr});
            if (vecs[v].chk_wdata) check({vecs[v].name, "_wdata"}, ram_wdata, vecs[v].e_wdata);
            next_cycle();
            idle();
            next_cycle();
        end

        // Load back what the table stored.
        for (int k = 0; k < 7; k++) begin
            d_load(lds[k].addr, lds[k].byteop);
            @(negedge CLK);
            check("ld_gnt", {31'd0, d_gnt}, 32'd1);
            next_cycle();
            idle();
            $display("load %0d addr=%h byte=%b rvalid=%b rdata=%h", k, lds[k].addr, lds[k].byteop, d_rvalid, d_rdata);
            check("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
            check("ld_rdata", d_rdata, lds[k].exp);
            check("ld_no_i_rvalid", {31'd0, i_rvalid}, 32'd0);
            next_cycle();
        end

        // Fetch only from word 4.
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge CLK);
        check("fetch_gnt", {31'd0, i_gnt}, 32'd1);
        next_cycle();
        idle();
        check("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("fetch_rdata", i_rdata, 32'hDEADBEEF);
        next_cycle();
        check("fetch_rvalid_low", {31'd0, i_rvalid}, 32'd0);
        check("fetch_rdata_hold", i_rdata, 32'hDEADBEEF);

        // Byte store to 0x13, then byte and word load back.
        d_req = 1'b1; d_we = 1'b1; d_byteop = 1'b1; d_addr = 32'h13; d_wdata = 32'h000000AB;
        @(negedge CLK);
        check("bst13_gnt", {31'd0, d_gnt}, 32'd1);
        check("bst13_be", {28'd0, ram_be}, 32'h8);
        check("bst13_wdata", ram_wdata, 32'hABABABAB);
        next_cycle();
        idle();
        d_load(32'h13, 1'b1);
        next_cycle();
        idle();
        check("bld13_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("bld13_rdata", d_rdata, 32'h000000AB);
        d_load(32'h10, 1'b0);
        next_cycle();
        idle();
        check("wld10_rdata", d_rdata, 32'hABADBEEF);
        next_cycle();

        // Contention held for six cycles: D D I D D I, each return one cycle later.
        exp_d = 6'b011011;
        pat = 6'd0;
        i_req = 1'b1; i_addr = 32'h10;
        d_load(32'h20, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            $display("contention cycle %0d: i_gnt=%b d_gnt=%b i_rvalid=%b d_rvalid=%b", k, i_gnt, d_gnt, i_rvalid, d_rvalid);
            check("cont_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d[k]});
            check("cont_i_gnt", {31'd0, i_gnt}, {31'd0, ~exp_d[k]});
            if (k > 0) begin
                check("cont_d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d[k-1]});
                check("cont_i_rvalid", {31'd0, i_rvalid}, {31'd0, ~exp_d[k-1]});
            end
            pat[k] = d_gnt;
            next_cycle();
        end
        idle();
        next_cycle();

        // A cycle without fetch request clears the burst count.
        i_req = 1'b1; i_addr = 32'h10;
        d_load(32'h20, 1'b0);
        next_cycle();
        next_cycle();
        i_req = 1'b0;
        @(negedge CLK);
        check("clr_d_only_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        i_req = 1'b1;
        @(negedge CLK);
        check("clr_after_gnt3", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        @(negedge CLK);
        check("clr_after_gnt4", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        @(negedge CLK);
        check("clr_after_gnt5_i", {31'd0, i_gnt}, 32'd1);
        next_cycle();
        idle();
        next_cycle();

        // Back-to-back fetch then data read, no bubble.
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge CLK);
        check("b2b_i_gnt", {31'd0, i_gnt}, 32'd1);
        next_cycle();
        idle();
        d_load(32'h40, 1'b0);
        @(negedge CLK);
        check("b2b_d_gnt", {31'd0, d_gnt}, 32'd1);
        check("b2b_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("b2b_i_rdata", i_rdata, 32'hABADBEEF);
        next_cycle();
        idle();
        check("b2b_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("b2b_d_rdata", d_rdata, 32'h002211CD);
        check("b2b_i_rvalid_low", {31'd0, i_rvalid}, 32'd0);
        next_cycle();

        // Reset in the cycle after a data read grant drops the return.
        d_load(32'h20, 1'b0);
        @(negedge CLK);
        check("rmid_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        idle();
        Reset = 1'b1;
        @(negedge CLK);
        check("rmid_d_rvalid_in_rst", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        Reset = 1'b0;
        check("rmid_d_rvalid_after", {31'd0, d_rvalid}, 32'd0);
        check("rmid_i_rvalid_after", {31'd0, i_rvalid}, 32'd0);
        check("rmid_d_rdata_after", d_rdata, 32'd0);
        check("rmid_i_rdata_after", i_rdata, 32'd0);
        next_cycle();
        check("rmid_d_rvalid_later", {31'd0, d_rvalid}, 32'd0);

        // Idle for five cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("idle_ram_en", {31'd0, ram_en}, 32'd0);
            check("idle_i_rvalid", {31'd0, i_rvalid}, 32'd0);
            check("idle_d_rvalid", {31'd0, d_rvalid}, 32'd0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_D_BURST, default 2: max consecutive data grants while fetch is waiting.
REQ-002 Parameter RAM_AW, default 10: RAM word-address width.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  fetch read request, held until i_gnt.
REQ-006 i_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-007 i_gnt  out  1  fetch request accepted this cycle.
REQ-008 i_rvalid  out  1  i_rdata valid.
REQ-009 i_rdata  out  32  fetched word.
REQ-010 d_req  in  1  data request, held with stable attributes until d_gnt.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_byteop  in  1  1 = byte access, 0 = word access.
REQ-013 d_addr  in  32  data byte address.
REQ-014 d_wdata  in  32  store data; byte store uses bits [7:0].
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  d_rdata valid (loads only).
REQ-017 d_rdata  out  32  load data; byte load zero-extended.
REQ-018 ram_en  out  1  RAM access this cycle.
REQ-019 ram_we  out  1  RAM write.
REQ-020 ram_be  out  4  byte-lane write enables.
REQ-021 ram_addr  out  RAM_AW  word address, equal to the selected address bits [RAM_AW+1:2].
REQ-022 ram_wdata  out  32  write data.
REQ-023 ram_rdata  in  32  read data, valid one cycle after a read access.

Function
REQ-024 Each cycle at most one request is granted; i_gnt, d_gnt, ram_en and ram_we are combinational from req inputs and state.
REQ-025 Only d_req: grant data. Only i_req: grant fetch. Neither: ram_en = 0.
REQ-026 Both requesting: grant data when burst_cnt < MAX_D_BURST; otherwise grant fetch.
REQ-027 burst_cnt increments (saturating at MAX_D_BURST) on a data grant while i_req = 1; it clears to 0 on a fetch grant, or on any cycle with i_req = 0.
REQ-028 Word store: ram_be = 4'b1111, ram_wdata = d_wdata.
REQ-029 Byte store: ram_be is one-hot at lane d_addr[1:0] (lane 0 = bits [7:0]); ram_wdata is d_wdata[7:0] replicated to all four lanes.
REQ-030 Reads drive ram_be = 0 and ram_we = 0; fetch grants are always reads.
REQ-031 On a read grant, register rd_owner (I or D) and rd_byte (byteop plus addr[1:0]); rvalid to that owner rises exactly 1 cycle after the grant.
REQ-032 Read-return FSM states: IDLE, RET_I, RET_D. Next state is RET_I or RET_D after a fetch or data read grant respectively, otherwise IDLE.
REQ-033 In RET_I, i_rvalid = 1 and i_rdata = ram_rdata. In RET_D, d_rvalid = 1 and d_rdata = ram_rdata, or for a byte load the selected lane zero-extended.
REQ-034 Back-to-back grants are allowed every cycle; a new grant may occur in the same cycle as a read return (full throughput).
REQ-035 d_rdata and i_rdata hold their last value when their rvalid is 0.
REQ-036 Stores produce no rvalid; a store followed by a load of the same address returns the stored data.

Reset
REQ-037 While Reset = 1: i_gnt = d_gnt = ram_en = ram_we = 0, ram_be = 0, and the FSM is forced to IDLE.
REQ-038 In the cycle after Reset: burst_cnt = 0, i_rvalid = d_rvalid = 0, and i_rdata = d_rdata = 0.
REQ-039 Reset asserted in the cycle after a read grant suppresses that read's rvalid; the return is dropped.

Structure
REQ-040 A shared package holds the FSM state enum (IDLE, RET_I, RET_D), the owner encoding, and the MAX_D_BURST / RAM_AW defaults.
REQ-041 Sub-module mem_byte_lane performs store lane steering (be/wdata) and load lane extraction; the arbiter and FSM stay in mem_arbiter.

Verification
REQ-042 Fetch only: i_req with i_addr = 0x10, RAM word 4 = 0xDEADBEEF -> i_gnt in the same cycle, next cycle i_rvalid = 1 with i_rdata = 0xDEADBEEF.
REQ-043 Byte store: d_addr = 0x13, d_wdata = 0xAB -> ram_be = 4'b1000, ram_wdata = 0xABABABAB; a later byte load from 0x13 gives d_rdata = 0x000000AB.
REQ-044 Contention: i_req and d_req held for 6 cycles -> grant pattern D, D, I, D, D, I.
REQ-045 Back-to-back: fetch read then data read on consecutive cycles -> i_rvalid, then d_rvalid, each in the cycle after its grant, with no bubble.
REQ-046 Reset mid-operation: Reset asserted the cycle after a data read grant -> d_rvalid stays 0, and the FSM is in IDLE afterwards.
REQ-047 Idle: no requests for 5 cycles -> ram_en = 0 and both rvalid = 0 throughout.
